alu_pipe_core: RTL and testbench

- Parametrised, two-stage pipelined ALU; successor to the fixed 8-bit combinational ALU.
- Takes operands and a 4-bit opcode through a valid/ready handshake on input and output.
- Produces result plus carry, zero, overflow and error flags.
- Counts completed transactions; sits behind the driver-facing ALU interface.

---
 rtl/alu_pipe_core.sv | 193 +++++++++++++++++++
 tb/tb_alu_pipe_core.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe_core.sv
// Two-stage elastic ALU pipeline with valid/ready handshakes and a completed-transfer counter.
// Define ALU_SAT_EN to enable saturating unsigned add/sub on opcodes D/E (otherwise illegal).
module alu_pipe_core #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alu_valid_in,
    output logic             alu_ready_out,
    input  logic [WIDTH-1:0] alu_a_in,
    input  logic [WIDTH-1:0] alu_b_in,
    input  logic [3:0]       alu_opcode_in,
    output logic             alu_valid_out,
    input  logic             alu_ready_in,
    output logic [WIDTH-1:0] alu_y_out,
    output logic             alu_co_out,
    output logic             alu_zero_out,
    output logic             alu_ovf_out,
    output logic             alu_err_out,
    output logic [CNT_W-1:0] alu_op_count_out
);

    localparam logic [3:0] OpAdd  = 4'h0;
    localparam logic [3:0] OpSub  = 4'h1;
    localparam logic [3:0] OpAnd  = 4'h2;
    localparam logic [3:0] OpOr   = 4'h3;
    localparam logic [3:0] OpXor  = 4'h4;
    localparam logic [3:0] OpNot  = 4'h5;
    localparam logic [3:0] OpShl  = 4'h6;
    localparam logic [3:0] OpShr  = 4'h7;
    localparam logic [3:0] OpInc  = 4'h8;
    localparam logic [3:0] OpDec  = 4'h9;
    localparam logic [3:0] OpRol  = 4'hA;
    localparam logic [3:0] OpRor  = 4'hB;
    localparam logic [3:0] OpPass = 4'hC;
`ifdef ALU_SAT_EN
    localparam logic [3:0] OpSadd = 4'hD;
    localparam logic [3:0] OpSsub = 4'hE;
`endif

    localparam int unsigned Msb = WIDTH - 1;

    // Stage 1: registered operands
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [3:0]       s1_op;

    // Stage 2: registered result and flags
    logic             s2_valid;
    logic [WIDTH-1:0] s2_y;
    logic             s2_co;
    logic             s2_zero;
    logic             s2_ovf;
    logic             s2_err;
    logic [CNT_W-1:0] op_count;

    logic s1_ready;
    logic s2_ready;

    assign s2_ready      = !s2_valid || alu_ready_in;
    assign s1_ready      = !s1_valid || s2_ready;
    assign alu_ready_out = s1_ready;

    // Combinational compute on stage-1 contents
    logic [WIDTH-1:0] c_y;
    logic             c_co;
    logic             c_ovf;
    logic             c_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   inc;
    logic [WIDTH:0]   dec;

    always_comb begin
        sum   = {1'b0, s1_a} + {1'b0, s1_b};
        diff  = {1'b0, s1_a} - {1'b0, s1_b};
        inc   = {1'b0, s1_a} + {{WIDTH{1'b0}}, 1'b1};
        dec   = {1'b0, s1_a} - {{WIDTH{1'b0}}, 1'b1};
        c_y   = '0;
        c_co  = 1'b0;
        c_ovf = 1'b0;
        c_err = 1'b0;
        case (s1_op)
            OpAdd: begin
                c_y   = sum[WIDTH-1:0];
                c_co  = sum[WIDTH];
                c_ovf = (s1_a[Msb] == s1_b[Msb]) && (sum[Msb] != s1_a[Msb]);
            end
            OpSub: begin
                c_y   = diff[WIDTH-1:0];
                c_co  = diff[WIDTH];
                c_ovf = (s1_a[Msb] != s1_b[Msb]) && (diff[Msb] != s1_a[Msb]);
            end
            OpAnd:  c_y = s1_a & s1_b;
            OpOr:   c_y = s1_a | s1_b;
            OpXor:  c_y = s1_a ^ s1_b;
            OpNot:  c_y = ~s1_a;
            OpPass: c_y = s1_b;
            OpShl: begin
                c_y  = {s1_a[WIDTH-2:0], 1'b0};
                c_co = s1_a[Msb];
            end
            OpShr: begin
                c_y  = {1'b0, s1_a[WIDTH-1:1]};
                c_co = s1_a[0];
            end
            OpInc: begin
                c_y   = inc[WIDTH-1:0];
                c_co  = inc[WIDTH];
                c_ovf = !s1_a[Msb] && inc[Msb];
            end
            OpDec: begin
                c_y   = dec[WIDTH-1:0];
                c_co  = dec[WIDTH];
                c_ovf = s1_a[Msb] && !dec[Msb];
            end
            OpRol: begin
                c_y  = {s1_a[WIDTH-2:0], s1_a[Msb]};
                c_co = s1_a[Msb];
            end
            OpRor: begin
                c_y  = {s1_a[0], s1_a[WIDTH-1:1]};
                c_co = s1_a[0];
            end
`ifdef ALU_SAT_EN
            OpSadd: begin
                c_y  = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
                c_co = sum[WIDTH];
            end
            OpSsub: begin
                c_y  = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
                c_co = diff[WIDTH];
            end
`endif
            default: c_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (s1_ready) begin
            s1_valid <= alu_valid_in;
            if (alu_valid_in) begin
                s1_a  <= alu_a_in;
                s1_b  <= alu_b_in;
                s1_op <= alu_opcode_in;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid <= 1'b0;
            s2_y     <= '0;
            s2_co    <= 1'b0;
            s2_zero  <= 1'b0;
            s2_ovf   <= 1'b0;
            s2_err   <= 1'b0;
        end else if (s2_ready) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_y    <= c_y;
                s2_co   <= c_co;
                s2_zero <= (c_y == '0);
                s2_ovf  <= c_ovf;
                s2_err  <= c_err;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_count <= '0;
        end else if (s2_valid && alu_ready_in) begin
            op_count <= op_count + 1'b1;
        end
    end

    assign alu_valid_out    = s2_valid;
    assign alu_y_out        = s2_y;
    assign alu_co_out       = s2_co;
    assign alu_zero_out     = s2_zero;
    assign alu_ovf_out      = s2_ovf;
    assign alu_err_out      = s2_err;
    assign alu_op_count_out = op_count;

endmodule

// File: tb/tb_alu_pipe_core.sv
// Directed self-checking bench for alu_pipe_core (WIDTH=8); honours ALU_SAT_EN if defined.
module tb_alu_pipe_core;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid_in;
    logic        alu_ready_out;
    logic [7:0]  alu_a_in;
    logic [7:0]  alu_b_in;
    logic [3:0]  alu_opcode_in;
    logic        alu_valid_out;
    logic        alu_ready_in;
    logic [7:0]  alu_y_out;
    logic        alu_co_out;
    logic        alu_zero_out;
    logic        alu_ovf_out;
    logic        alu_err_out;
    logic [15:0] alu_op_count_out;

    int tests_run = 0;
    int tests_failed = 0;
    logic [15:0] exp_count = 16'd0;

    always #5 clk = ~clk;

    alu_pipe_core #(.WIDTH(8), .CNT_W(16)) dut (
        .clk              (clk),
        .reset            (reset),
        .alu_valid_in     (alu_valid_in),
        .alu_ready_out    (alu_ready_out),
        .alu_a_in         (alu_a_in),
        .alu_b_in         (alu_b_in),
        .alu_opcode_in    (alu_opcode_in),
        .alu_valid_out    (alu_valid_out),
        .alu_ready_in     (alu_ready_in),
        .alu_y_out        (alu_y_out),
        .alu_co_out       (alu_co_out),
        .alu_zero_out     (alu_zero_out),
        .alu_ovf_out      (alu_ovf_out),
        .alu_err_out      (alu_err_out),
        .alu_op_count_out (alu_op_count_out)
    );

    task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        alu_valid_in  = 1'b1;
        alu_opcode_in = op;
        alu_a_in      = a;
        alu_b_in      = b;
    endtask

    // Sends one op with ready_in=1, waits (bounded) for the result, then lets it transfer.
    // res = {y, co, zero, ovf, err}; lat = edges from input transfer to valid_out.
    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          output logic [11:0] res, output int lat);
        alu_ready_in = 1'b1;
        drive(op, a, b);
        @(posedge clk); #1;
        alu_valid_in = 1'b0;
        lat = 1;
        while (!alu_valid_out && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {alu_y_out, alu_co_out, alu_zero_out, alu_ovf_out, alu_err_out};
        @(posedge clk); #1;
        exp_count++;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        alu_valid_in = 1'b0;
        alu_ready_in = 1'b0;
        alu_a_in = '0;
        alu_b_in = '0;
        alu_opcode_in = '0;
        #12;
        tests_run++;
        if ({alu_valid_out, alu_y_out, alu_co_out, alu_zero_out, alu_ovf_out, alu_err_out}
            !== 13'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b y=%h co=%b z=%b o=%b e=%b want all 0",
                     alu_valid_out, alu_y_out, alu_co_out, alu_zero_out, alu_ovf_out,
                     alu_err_out);
        end
        tests_run++;
        if (alu_op_count_out !== 16'd0) begin
            tests_failed++;
            $display("FAIL reset_count: got %0d want 0", alu_op_count_out);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (alu_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready: got %b want 1", alu_ready_out);
        end
    endtask

    task automatic test_add_sub();
        logic [11:0] r;
        int lat;
        run_op(4'h0, 8'hF0, 8'h20, r, lat);
        tests_run++;
        if (lat !== 2) begin
            tests_failed++;
            $display("FAIL add_latency: got %0d want 2", lat);
        end
        tests_run++;
        if (r !== {8'h10, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_carry: got %h want %h", r, {8'h10, 4'b1000});
        end
        tests_run++;
        if (alu_op_count_out !== 16'd1) begin
            tests_failed++;
            $display("FAIL add_count: got %0d want 1", alu_op_count_out);
        end
        run_op(4'h0, 8'h7F, 8'h01, r, lat);
        tests_run++;
        if (r !== {8'h80, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL add_ovf: got %h want %h", r, {8'h80, 4'b0010});
        end
        run_op(4'h1, 8'h05, 8'h05, r, lat);
        tests_run++;
        if (r !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_zero: got %h want %h", r, {8'h00, 4'b0100});
        end
        run_op(4'h1, 8'h03, 8'h05, r, lat);
        tests_run++;
        if (r !== {8'hFE, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_borrow: got %h want %h", r, {8'hFE, 4'b1000});
        end
        run_op(4'h1, 8'h80, 8'h01, r, lat);
        tests_run++;
        if (r !== {8'h7F, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL sub_ovf: got %h want %h", r, {8'h7F, 4'b0010});
        end
    endtask

    task automatic test_shift_rotate();
        logic [11:0] r;
        int lat;
        run_op(4'h6, 8'h81, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'h02, 4'b1000}) begin
            tests_failed++;
            $display("FAIL shl: got %h want %h", r, {8'h02, 4'b1000});
        end
        run_op(4'h7, 8'h81, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'h40, 4'b1000}) begin
            tests_failed++;
            $display("FAIL shr: got %h want %h", r, {8'h40, 4'b1000});
        end
        run_op(4'hB, 8'h01, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'h80, 4'b1000}) begin
            tests_failed++;
            $display("FAIL ror: got %h want %h", r, {8'h80, 4'b1000});
        end
        run_op(4'hA, 8'h80, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'h01, 4'b1000}) begin
            tests_failed++;
            $display("FAIL rol: got %h want %h", r, {8'h01, 4'b1000});
        end
    endtask

    task automatic test_logic_incdec();
        logic [11:0] r;
        int lat;
        run_op(4'h2, 8'hCC, 8'hAA, r, lat);
        tests_run++;
        if (r !== {8'h88, 4'b0000}) begin
            tests_failed++;
            $display("FAIL and: got %h want %h", r, {8'h88, 4'b0000});
        end
        run_op(4'h4, 8'hCC, 8'hAA, r, lat);
        tests_run++;
        if (r !== {8'h66, 4'b0000}) begin
            tests_failed++;
            $display("FAIL xor: got %h want %h", r, {8'h66, 4'b0000});
        end
        run_op(4'h5, 8'hFF, 8'h12, r, lat);
        tests_run++;
        if (r !== {8'h00, 4'b0100}) begin
            tests_failed++;
            $display("FAIL not: got %h want %h", r, {8'h00, 4'b0100});
        end
        run_op(4'hC, 8'h11, 8'h5A, r, lat);
        tests_run++;
        if (r !== {8'h5A, 4'b0000}) begin
            tests_failed++;
            $display("FAIL pass: got %h want %h", r, {8'h5A, 4'b0000});
        end
        run_op(4'h8, 8'h7F, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'h80, 4'b0010}) begin
            tests_failed++;
            $display("FAIL inc_ovf: got %h want %h", r, {8'h80, 4'b0010});
        end
        run_op(4'h8, 8'hFF, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'h00, 4'b1100}) begin
            tests_failed++;
            $display("FAIL inc_wrap: got %h want %h", r, {8'h00, 4'b1100});
        end
        run_op(4'h9, 8'h00, 8'h00, r, lat);
        tests_run++;
        if (r !== {8'hFF, 4'b1000}) begin
            tests_failed++;
            $display("FAIL dec_borrow: got %h want %h", r, {8'hFF, 4'b1000});
        end
    endtask

    task automatic test_illegal();
        logic [11:0] r;
        int lat;
        run_op(4'hF, 8'h12, 8'h34, r, lat);
        tests_run++;
        if (r !== {8'h00, 4'b0101}) begin
            tests_failed++;
            $display("FAIL illegal_f: got %h want %h", r, {8'h00, 4'b0101});
        end
        tests_run++;
        if (alu_op_count_out !== exp_count) begin
            tests_failed++;
            $display("FAIL illegal_count: got %0d want %0d", alu_op_count_out, exp_count);
        end
    endtask

    task automatic test_saturate();
        logic [11:0] r;
        logic [11:0] exp_d;
        logic [11:0] exp_e;
        int lat;
`ifdef ALU_SAT_EN
        exp_d = {8'hFF, 4'b1000};
        exp_e = {8'h00, 4'b1100};
`else
        exp_d = {8'h00, 4'b0101};
        exp_e = {8'h00, 4'b0101};
`endif
        run_op(4'hD, 8'hF0, 8'h20, r, lat);
        tests_run++;
        if (r !== exp_d) begin
            tests_failed++;
            $display("FAIL op_d: got %h want %h", r, exp_d);
        end
        run_op(4'hE, 8'h10, 8'h20, r, lat);
        tests_run++;
        if (r !== exp_e) begin
            tests_failed++;
            $display("FAIL op_e: got %h want %h", r, exp_e);
        end
    endtask

    task automatic test_back_to_back();
        alu_ready_in = 1'b0;
        drive(4'h0, 8'h01, 8'h02);
        tests_run++;
        if (alu_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready0: got %b want 1", alu_ready_out);
        end
        @(posedge clk); #1;
        drive(4'h1, 8'h10, 8'h01);
        tests_run++;
        if (alu_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ready1: got %b want 1", alu_ready_out);
        end
        @(posedge clk); #1;
        drive(4'h4, 8'hFF, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({alu_ready_out, alu_valid_out, alu_y_out, alu_co_out, alu_zero_out}
                !== {1'b0, 1'b1, 8'h03, 1'b0, 1'b0}) begin
                tests_failed++;
                $display("FAIL b2b_stall[%0d]: got rdy=%b v=%b y=%h co=%b z=%b want 0 1 03 0 0",
                         i, alu_ready_out, alu_valid_out, alu_y_out, alu_co_out, alu_zero_out);
            end
            @(posedge clk); #1;
        end
        alu_ready_in = 1'b1;
        #1;
        tests_run++;
        if (alu_ready_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_release_ready: got %b want 1", alu_ready_out);
        end
        @(posedge clk); #1;
        tests_run++;
        if ({alu_valid_out, alu_y_out} !== {1'b1, 8'h0F}) begin
            tests_failed++;
            $display("FAIL b2b_out1: got v=%b y=%h want 1 0f", alu_valid_out, alu_y_out);
        end
        drive(4'h3, 8'h0A, 8'h50);
        @(posedge clk); #1;
        tests_run++;
        if ({alu_valid_out, alu_y_out} !== {1'b1, 8'hF0}) begin
            tests_failed++;
            $display("FAIL b2b_out2: got v=%b y=%h want 1 f0", alu_valid_out, alu_y_out);
        end
        alu_valid_in = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if ({alu_valid_out, alu_y_out} !== {1'b1, 8'h5A}) begin
            tests_failed++;
            $display("FAIL b2b_out3: got v=%b y=%h want 1 5a", alu_valid_out, alu_y_out);
        end
        @(posedge clk); #1;
        exp_count = exp_count + 16'd4;
        tests_run++;
        if ({alu_valid_out, alu_op_count_out} !== {1'b0, exp_count}) begin
            tests_failed++;
            $display("FAIL b2b_drain: got v=%b cnt=%0d want 0 %0d", alu_valid_out,
                     alu_op_count_out, exp_count);
        end
    endtask

    task automatic test_reset_mid_op();
        logic [11:0] r;
        int lat;
        alu_ready_in = 1'b1;
        drive(4'h0, 8'h01, 8'h01);
        @(posedge clk); #1;
        drive(4'h0, 8'h02, 8'h02);
        @(posedge clk); #1;
        alu_valid_in = 1'b0;
        reset = 1'b0;
        #1;
        exp_count = 16'd0;
        tests_run++;
        if ({alu_valid_out, alu_op_count_out} !== 17'd0) begin
            tests_failed++;
            $display("FAIL midreset_clear: got v=%b cnt=%0d want 0 0", alu_valid_out,
                     alu_op_count_out);
        end
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (alu_valid_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_discard: got v=%b want 0", alu_valid_out);
        end
        run_op(4'h0, 8'h03, 8'h04, r, lat);
        tests_run++;
        if (lat !== 2 || r !== {8'h07, 4'b0000}) begin
            tests_failed++;
            $display("FAIL midreset_newop: got lat=%0d res=%h want 2 %h", lat, r,
                     {8'h07, 4'b0000});
        end
        tests_run++;
        if (alu_op_count_out !== 16'd1) begin
            tests_failed++;
            $display("FAIL midreset_count: got %0d want 1", alu_op_count_out);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub();
        test_shift_rotate();
        test_logic_incdec();
        test_illegal();
        test_saturate();
        test_back_to_back();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
